operand_stage: RTL and testbench

- Upstream operand staging block: accepts opa/opb pairs from the requester over a valid/ready handshake.
- Buffers pairs in a small FIFO and presents one registered pair per cycle to the downstream adder/select stage (the consumer of opa_r/opb_r/cond).
- Precomputes the sign-zero condition alongside the data, so the consumer receives operands and cond in the same cycle.
- Optional bypass (fast) removes one cycle of latency when the FIFO is empty.

---
 rtl/operand_pkg.sv | 16 +
 rtl/operand_stage_if.sv | 29 ++
 rtl/operand_fifo.sv | 62 ++++++
 rtl/operand_stage.sv | 99 +++++++++
 tb/tb_operand_stage.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/operand_pkg.sv
// Operand staging types shared with the downstream adder/select stage.
package operand_pkg;

    localparam int OP_WIDTH = 32;

    typedef struct packed {
        logic [OP_WIDTH-1:0] opa;
        logic [OP_WIDTH-1:0] opb;
    } pair_t;

    // True when neither operand has its sign bit set.
    function automatic logic sign_zero(input logic sign_a, input logic sign_b);
        return ~(sign_a | sign_b);
    endfunction

endpackage

// File: rtl/operand_stage_if.sv
// Requester and consumer handshake bundle of the operand stage.
interface operand_stage_if
    import operand_pkg::*;
#(
    parameter int WIDTH = OP_WIDTH,
    parameter int CNTW  = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             fast;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] opa_r;
    logic [WIDTH-1:0] opb_r;
    logic             cond;
    logic [CNTW-1:0]  pair_cnt;

    modport master (
        output in_valid, opa, opb, fast, out_ready,
        input  in_ready, out_valid, opa_r, opb_r, cond, pair_cnt
    );

    modport slave (
        input  in_valid, opa, opb, fast, out_ready,
        output in_ready, out_valid, opa_r, opb_r, cond, pair_cnt
    );
endinterface

// File: rtl/operand_fifo.sv
// Small pair FIFO with power-of-two depth and occupancy count.
// Latency: write visible at the head the cycle after it is written.
// Backpressure: writes while full and reads while empty are dropped.
module operand_fifo
    import operand_pkg::*;
#(
    parameter int DW    = 2 * OP_WIDTH,
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_dat,
    input  logic          rd_en,
    output logic [DW-1:0] rd_dat,
    output logic [CW-1:0] count,
    output logic          empty
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          wr_ok;
    logic          rd_ok;

    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    assign wr_ok  = wr_en & ~full;
    assign rd_ok  = rd_en & ~empty;
    assign rd_dat = mem[rd_ptr];

    // Storage carries no reset; validity is tracked solely by count.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/operand_stage.sv
// Stages opa/opb pairs into a registered output with precomputed sign-zero cond.
// Latency: 1 cycle on the fast bypass with an empty FIFO, otherwise 2 or more.
// Backpressure: in_ready drops only when the FIFO is full, independent of out_ready.
module operand_stage
    import operand_pkg::*;
#(
    parameter int WIDTH = OP_WIDTH,
    parameter int DEPTH = 2,
    parameter int CNTW  = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    operand_stage_if.slave bus
);

    localparam int CW = $clog2(DEPTH + 1);

    // Local pair layout so WIDTH may differ from the package default.
    typedef struct packed {
        logic [WIDTH-1:0] opa;
        logic [WIDTH-1:0] opb;
    } stage_pair_t;

    stage_pair_t     in_pair;
    stage_pair_t     head_pair;
    stage_pair_t     load_pair;
    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    logic            in_rdy;
    logic            push;
    logic            pop;
    logic            load_en;
    logic            fifo_rd;
    logic            fifo_wr;
    logic            bypass;

    logic             out_vld;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic             cond_q;
    logic [CNTW-1:0]  pair_cnt_q;

    assign in_pair = '{opa: bus.opa, opb: bus.opb};

    assign in_rdy  = (fifo_count < CW'(DEPTH));
    assign push    = bus.in_valid & in_rdy;
    assign pop     = out_vld & bus.out_ready;
    assign load_en = ~out_vld | pop;

    // FIFO head always wins so order is preserved; bypass only when it is empty.
    assign fifo_rd   = load_en & ~fifo_empty;
    assign bypass    = load_en & fifo_empty & bus.fast & push;
    assign fifo_wr   = push & ~bypass;
    assign load_pair = fifo_rd ? head_pair : in_pair;

    operand_fifo #(
        .DW    (2 * WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (fifo_wr),
        .wr_dat (in_pair),
        .rd_en  (fifo_rd),
        .rd_dat (head_pair),
        .count  (fifo_count),
        .empty  (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld    <= 1'b0;
            opa_q      <= '0;
            opb_q      <= '0;
            cond_q     <= 1'b1;
            pair_cnt_q <= '0;
        end else begin
            if (fifo_rd | bypass) begin
                out_vld <= 1'b1;
                opa_q   <= load_pair.opa;
                opb_q   <= load_pair.opb;
                cond_q  <= sign_zero(load_pair.opa[WIDTH-1], load_pair.opb[WIDTH-1]);
            end else if (pop) begin
                out_vld <= 1'b0;
            end
            if (push) begin
                pair_cnt_q <= pair_cnt_q + CNTW'(1);
            end
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_vld;
    assign bus.opa_r     = opa_q;
    assign bus.opb_r     = opb_q;
    assign bus.cond      = cond_q;
    assign bus.pair_cnt  = pair_cnt_q;

endmodule

// File: tb/tb_operand_stage.sv
// Directed and streaming checks of operand_stage at WIDTH=32, DEPTH=2, CNTW=16.
module tb_operand_stage;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    operand_stage_if #(.WIDTH(32), .CNTW(16)) bus ();

    operand_stage #(
        .WIDTH (32),
        .DEPTH (2),
        .CNTW  (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid = vld;
        bus.opa      = a;
        bus.opb      = b;
    endtask

    logic [63:0] q[$];
    logic [63:0] exp_pair;

    initial begin
        int pushed;
        int cyc;
        n_tests       = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.opa       = '0;
        bus.opb       = '0;
        bus.fast      = 1'b0;
        bus.out_ready = 1'b0;

        #12;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_opa_r", bus.opa_r, 0);
        chk("rst_opb_r", bus.opb_r, 0);
        chk("rst_cond", bus.cond, 1);
        chk("rst_pair_cnt", bus.pair_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rel_in_ready", bus.in_ready, 1);

        // Fast bypass: one-cycle latency.
        bus.fast      = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h0000_0005, 32'h0000_0003);
        tick();
        drive(1'b0, '0, '0);
        chk("byp_out_valid", bus.out_valid, 1);
        chk("byp_opa_r", bus.opa_r, 32'h5);
        chk("byp_opb_r", bus.opb_r, 32'h3);
        chk("byp_cond", bus.cond, 1);
        chk("byp_pair_cnt", bus.pair_cnt, 1);
        tick();
        chk("byp_drained", bus.out_valid, 0);

        // Through the FIFO: two-cycle latency, negative signs clear cond.
        bus.fast = 1'b0;
        drive(1'b1, 32'h8000_0000, 32'h0000_0001);
        tick();
        drive(1'b0, '0, '0);
        chk("fifo_lat1_valid", bus.out_valid, 0);
        tick();
        chk("fifo_lat2_valid", bus.out_valid, 1);
        chk("fifo_opa_r", bus.opa_r, 32'h8000_0000);
        chk("fifo_cond_a_neg", bus.cond, 0);
        drive(1'b1, 32'h0000_0001, 32'h8000_0001);
        tick();
        drive(1'b0, '0, '0);
        chk("fifo2_lat1_valid", bus.out_valid, 0);
        tick();
        chk("fifo2_valid", bus.out_valid, 1);
        chk("fifo2_opb_r", bus.opb_r, 32'h8000_0001);
        chk("fifo2_cond_b_neg", bus.cond, 0);
        chk("fifo2_pair_cnt", bus.pair_cnt, 3);
        tick();

        // Fill under backpressure: A in output, B and C in the FIFO.
        bus.out_ready = 1'b0;
        drive(1'b1, 32'hAAAA_0001, 32'h0000_00A1);
        tick();
        drive(1'b1, 32'hBBBB_0002, 32'h0000_00B2);
        tick();
        drive(1'b1, 32'hCCCC_0003, 32'h0000_00C3);
        tick();
        chk("full_in_ready", bus.in_ready, 0);
        chk("full_head_A", bus.opa_r, 32'hAAAA_0001);
        chk("full_pair_cnt", bus.pair_cnt, 6);
        drive(1'b1, 32'hDDDD_0004, 32'h0000_00D4);
        tick();
        chk("full_reject_cnt", bus.pair_cnt, 6);
        chk("full_hold_A", bus.opa_r, 32'hAAAA_0001);

        // Drain: D stays offered during the first pop and must still be refused.
        bus.out_ready = 1'b1;
        chk("pop1_in_ready", bus.in_ready, 0);
        tick();
        drive(1'b0, '0, '0);
        chk("pop1_reject_cnt", bus.pair_cnt, 6);
        chk("pop1_in_ready_up", bus.in_ready, 1);
        chk("pop1_B", bus.opa_r, 32'hBBBB_0002);
        tick();
        chk("pop2_C", bus.opa_r, 32'hCCCC_0003);
        chk("pop2_C_opb", bus.opb_r, 32'h0000_00C3);
        chk("pop2_valid", bus.out_valid, 1);
        tick();
        chk("pop3_empty", bus.out_valid, 0);

        // Streaming with fast toggling every cycle against a scoreboard.
        pushed = 0;
        cyc    = 0;
        while (pushed < 1000 && cyc < 5000) begin
            bus.fast = cyc[0];
            drive(1'b1, $urandom, $urandom);
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    chk("str_extra", 1, 0);
                end else begin
                    exp_pair = q.pop_front();
                    chk("str_opa", bus.opa_r, exp_pair[63:32]);
                    chk("str_opb", bus.opb_r, exp_pair[31:0]);
                    chk("str_cond", bus.cond, !(exp_pair[63] || exp_pair[31]));
                end
            end
            if (bus.in_ready) begin
                q.push_back({bus.opa, bus.opb});
                pushed++;
            end
            tick();
            cyc++;
        end
        drive(1'b0, '0, '0);
        for (int i = 0; i < 10; i++) begin
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    chk("drain_extra", 1, 0);
                end else begin
                    exp_pair = q.pop_front();
                    chk("drain_opa", bus.opa_r, exp_pair[63:32]);
                    chk("drain_opb", bus.opb_r, exp_pair[31:0]);
                end
            end
            tick();
        end
        chk("str_pushed", pushed, 1000);
        chk("str_leftover", q.size(), 0);

        // Reset with two pairs buffered.
        bus.fast      = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h1111_1111, 32'h2222_2222);
        tick();
        drive(1'b1, 32'h3333_3333, 32'h4444_4444);
        tick();
        drive(1'b0, '0, '0);
        chk("pre_rst_valid", bus.out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_opa_r", bus.opa_r, 0);
        chk("mid_rst_cond", bus.cond, 1);
        chk("mid_rst_pair_cnt", bus.pair_cnt, 0);
        @(negedge clk);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_no_stale", bus.out_valid, 0);
        end

        // Counter wrap after 65535 + 1 pushes.
        bus.fast = 1'b1;
        drive(1'b1, 32'h0000_0001, 32'h0000_0002);
        pushed = 0;
        cyc    = 0;
        while (pushed < 65535 && cyc < 70000) begin
            if (bus.in_ready) pushed++;
            tick();
            cyc++;
        end
        chk("wrap_pre", bus.pair_cnt, 16'hFFFF);
        chk("wrap_in_ready", bus.in_ready, 1);
        tick();
        drive(1'b0, '0, '0);
        chk("wrap_zero", bus.pair_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
